ar_mem_reader: RTL
==================

// Module: ar_mem_reader
// PURPOSE
//  Address-register and memory-read sequencer that consumes the PC's AR_data_out.
//  Latches an address from the PC (or directly from the bus) into AR.
//  Runs a req/ack read of instruction/data memory at that address.
//  Returns the read word in a data register (DR) for the bus, with a done pulse to the control unit.
// PARAMETERS
//  reg_width      12   address width (AR, PC side, mem_addr)
//  data_width     16   memory word / DR width
//  timeout_cycles 15   max cycles in REQ before abort (used only with AR_READ_TIMEOUT_EN)
// PORTS
//  clk          in   1            system clock, rising edge
//  reset        in   1            asynchronous, active-low; 0 = reset
//  pc_load      in   1            load AR from pc_addr_in
//  pc_addr_in   in   reg_width    address from PC (AR_data_out)
//  bus_load     in   1            load AR from bus_data_in
//  bus_data_in  in   reg_width    address from shared bus
//  ar_inc       in   1            AR <= AR + 1
//  read_req     in   1            start a memory read at current AR
//  mem_rdata    in   data_width   memory read data, valid with mem_ack
//  mem_ack      in   1            memory acknowledge
//  mem_addr     out  reg_width    memory address (= AR)
//  mem_req      out  1            memory request, registered
//  dr_data_out  out  data_width   data register to bus
//  read_done    out  1            1-cycle pulse: DR updated
//  read_err     out  1            1-cycle pulse: read aborted by timeout
//  busy         out  1            high whenever state != IDLE
// BEHAVIOUR
//  - Reset (async, reset=0): AR=0, DR=0, state=IDLE, mem_req/read_done/read_err/busy=0 immediately,
//    including mid-read; any outstanding ack after release is ignored.
//  - AR update, IDLE only, priority bus_load > pc_load > ar_inc; ar_inc wraps 2^reg_width-1 -> 0.
//    AR load/inc requests while busy are ignored; AR is stable for the whole read.
//  - mem_addr = AR combinationally.
//  - FSM states: IDLE, REQ, DONE, ERR.
//  - IDLE -> REQ: on read_req=1 at the edge. An AR load in the same cycle takes effect first,
//    so the read uses the new address. mem_req=1 from the next cycle.
//  - REQ -> DONE: mem_ack=1 sampled in REQ; DR <= mem_rdata at that edge; mem_req drops.
//  - DONE -> IDLE: unconditional. read_done=1 for exactly this cycle.
//    read_req is ignored here; back-to-back reads need read_req re-sampled in IDLE.
//  - mem_ack outside REQ is ignored; DR changes only on REQ->DONE.
//  - Minimum latency: read_req edge N, ack at edge N+1, read_done high during cycle N+2, IDLE at N+3.
// CONFIGURATION
//  - AR_READ_TIMEOUT_EN defined: a wait counter clears on entry to REQ and increments each REQ
//    cycle without ack. When it reaches timeout_cycles: REQ -> ERR (mem_req drops, DR unchanged),
//    read_err=1 for one cycle, ERR -> IDLE. Ack on the expiry cycle wins (goes to DONE).
//  - Not defined: no counter; REQ waits indefinitely; read_err tied 0.
// STRUCTURE
//  - proc_pkg: localparams for PC_WIDTH=12 and DATA_WIDTH=16.
//    Also the FSM state encoding: IDLE=2'd0, REQ=2'd1, DONE=2'd2, ERR=2'd3.
//  - One sub-module, ar_reg: AR with load-priority mux, increment and hold-while-busy.
//    FSM and DR stay in ar_mem_reader.
// TESTING
//  1. Reset release -> AR=0, mem_req=0, busy=0; pc_load with pc_addr_in=12'hE08 -> mem_addr=12'hE08 next cycle.
//  2. read_req at AR=12'hE08, mem_ack after 3 REQ cycles with mem_rdata=16'hBEEF
//     -> DR=16'hBEEF, read_done one cycle, busy low afterwards.
//  3. AR=12'hFFF, ar_inc -> AR=12'h000. bus_load=1 and pc_load=1 together -> AR takes bus_data_in.
//  4. pc_load/ar_inc during REQ -> AR unchanged. Stray mem_ack in IDLE -> DR unchanged, no read_done.
//  5. reset=0 mid-REQ -> mem_req=0 at once, state IDLE; later read completes normally.
//  6. AR_READ_TIMEOUT_EN, no ack -> read_err pulse after 15 REQ cycles, DR unchanged;
//     without macro, req held 100 cycles, read_err=0.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared widths and read-sequencer state encoding for the processor datapath.
package proc_pkg;

  localparam int PC_WIDTH   = 12;
  localparam int DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/ar_reg.sv
// Address register: bus_load > pc_load > ar_inc, frozen while a read is in flight.
module ar_reg
  import proc_pkg::*;
#(
  parameter int reg_width = PC_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hold,
  input  logic                 bus_load,
  input  logic [reg_width-1:0] bus_data_in,
  input  logic                 pc_load,
  input  logic [reg_width-1:0] pc_addr_in,
  input  logic                 ar_inc,
  output logic [reg_width-1:0] ar
);

  // Increment wraps naturally at 2^reg_width - 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ar <= '0;
    end else if (!hold) begin
      if (bus_load) begin
        ar <= bus_data_in;
      end else if (pc_load) begin
        ar <= pc_addr_in;
      end else if (ar_inc) begin
        ar <= ar + reg_width'(1);
      end
    end
  end

endmodule

// File: rtl/ar_mem_reader.sv
// AR latch plus req/ack memory read sequencer returning the word in DR.
// Optional read timeout enabled by defining AR_READ_TIMEOUT_EN.
module ar_mem_reader
  import proc_pkg::*;
#(
  parameter int reg_width  = PC_WIDTH,
  parameter int data_width = DATA_WIDTH
`ifdef AR_READ_TIMEOUT_EN
  ,
  parameter int timeout_cycles = 15
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pc_load,
  input  logic [reg_width-1:0]  pc_addr_in,
  input  logic                  bus_load,
  input  logic [reg_width-1:0]  bus_data_in,
  input  logic                  ar_inc,
  input  logic                  read_req,
  input  logic [data_width-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [reg_width-1:0]  mem_addr,
  output logic                  mem_req,
  output logic [data_width-1:0] dr_data_out,
  output logic                  read_done,
  output logic                  read_err,
  output logic                  busy
);

  rd_state_t             state;
  logic [reg_width-1:0]  ar;
  logic [data_width-1:0] dr;
  logic                  ar_hold;

`ifdef AR_READ_TIMEOUT_EN
  localparam int CNT_W = $clog2(timeout_cycles + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(timeout_cycles - 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             read_err_q;

  assign read_err = read_err_q;
`else
  assign read_err = 1'b0;
`endif

  // AR must not move between request and completion, so it is held outside IDLE.
  assign ar_hold     = (state != IDLE);
  assign mem_addr    = ar;
  assign dr_data_out = dr;

  ar_reg #(
    .reg_width (reg_width)
  ) u_ar_reg (
    .clk         (clk),
    .reset       (reset),
    .hold        (ar_hold),
    .bus_load    (bus_load),
    .bus_data_in (bus_data_in),
    .pc_load     (pc_load),
    .pc_addr_in  (pc_addr_in),
    .ar_inc      (ar_inc),
    .ar          (ar)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      dr        <= '0;
      mem_req   <= 1'b0;
      read_done <= 1'b0;
      busy      <= 1'b0;
`ifdef AR_READ_TIMEOUT_EN
      wait_cnt   <= '0;
      read_err_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (read_req) begin
            state   <= REQ;
            mem_req <= 1'b1;
            busy    <= 1'b1;
`ifdef AR_READ_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        // An ack on the final wait cycle still completes the read.
        REQ: begin
          if (mem_ack) begin
            state     <= DONE;
            dr        <= mem_rdata;
            mem_req   <= 1'b0;
            read_done <= 1'b1;
          end
`ifdef AR_READ_TIMEOUT_EN
          else if (wait_cnt == LAST_WAIT) begin
            state      <= ERR;
            mem_req    <= 1'b0;
            read_err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        DONE: begin
          state     <= IDLE;
          read_done <= 1'b0;
          busy      <= 1'b0;
        end
        ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
`ifdef AR_READ_TIMEOUT_EN
          read_err_q <= 1'b0;
`endif
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
